// File: rtl/vga_pattern_gen_if.sv
// Pixel-stage bus: coordinates, syncs and pattern request in; re-timed syncs and colour out.
interface vga_pattern_gen_if;
    logic       HSync_in;
    logic       VSync_in;
    logic [9:0] col;
    logic [9:0] row;
    logic       pattern_next;
    logic       HSync_out;
    logic       VSync_out;
    logic       R;
    logic       G;
    logic       B;

    modport master (
        output HSync_in, VSync_in, col, row, pattern_next,
        input  HSync_out, VSync_out, R, G, B
    );

    modport slave (
        input  HSync_in, VSync_in, col, row, pattern_next,
        output HSync_out, VSync_out, R, G, B
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern colour stage: two-clock pipeline from (col,row,syncs) to (R,G,B,syncs).
// Pattern and bouncing-box state only change on the first blanking line.
module vga_pattern_gen #(
    parameter int unsigned ACTIVE_COLS = 640,
    parameter int unsigned ACTIVE_ROWS = 480,
    parameter int unsigned BAR_WIDTH   = 80,
    parameter int unsigned CHECK_SHIFT = 5,
    parameter int unsigned BOX_SIZE    = 32
) (
    input  logic               clk,
    input  logic               rst,
    vga_pattern_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_BOX   = 2'd3
    } pattern_e;

    localparam logic [10:0] COLS11 = 11'(ACTIVE_COLS);
    localparam logic [10:0] ROWS11 = 11'(ACTIVE_ROWS);
    localparam logic [10:0] BOX11  = 11'(BOX_SIZE);
    localparam logic [10:0] X_MAX  = 11'(ACTIVE_COLS - BOX_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(ACTIVE_ROWS - BOX_SIZE);

    // Frame-rate state
    pattern_e    pattern_q, pattern_d;
    logic        pending_q, pending_d;
    logic [10:0] box_x_q, box_x_d;
    logic [10:0] box_y_q, box_y_d;
    logic        dx_neg_q, dx_neg_d;
    logic        dy_neg_q, dy_neg_d;

    // Stage 1
    logic        hs_s1_q, hs_s1_d;
    logic        vs_s1_q, vs_s1_d;
    logic        active_s1_q, active_s1_d;
    logic        inbox_s1_q, inbox_s1_d;
    logic        chk_s1_q, chk_s1_d;
    logic [2:0]  bar_s1_q, bar_s1_d;
    pattern_e    pat_s1_q, pat_s1_d;

    // Stage 2
    logic [2:0]  rgb_s2_q, rgb_s2_d;
    logic        hs_s2_q, hs_s2_d;
    logic        vs_s2_q, vs_s2_d;

    logic [10:0] col11, row11;
    logic        frame_tick;

    assign col11      = {1'b0, bus.col};
    assign row11      = {1'b0, bus.row};
    assign frame_tick = (col11 == 11'd0) && (row11 == ROWS11);

    // Pattern select and box motion, both advanced only on frame_tick
    always_comb begin
        pattern_d = pattern_q;
        pending_d = pending_q;
        box_x_d   = box_x_q;
        box_y_d   = box_y_q;
        dx_neg_d  = dx_neg_q;
        dy_neg_d  = dy_neg_q;
        if (frame_tick) begin
            if (pending_q || bus.pattern_next) begin
                pattern_d = pattern_e'(pattern_q + 2'd1);
            end
            pending_d = 1'b0;

            if (!dx_neg_q && box_x_q == X_MAX) begin
                dx_neg_d = 1'b1;
                box_x_d  = box_x_q - 11'd1;
            end else if (dx_neg_q && box_x_q == 11'd0) begin
                dx_neg_d = 1'b0;
                box_x_d  = box_x_q + 11'd1;
            end else begin
                box_x_d  = dx_neg_q ? box_x_q - 11'd1 : box_x_q + 11'd1;
            end

            if (!dy_neg_q && box_y_q == Y_MAX) begin
                dy_neg_d = 1'b1;
                box_y_d  = box_y_q - 11'd1;
            end else if (dy_neg_q && box_y_q == 11'd0) begin
                dy_neg_d = 1'b0;
                box_y_d  = box_y_q + 11'd1;
            end else begin
                box_y_d  = dy_neg_q ? box_y_q - 11'd1 : box_y_q + 11'd1;
            end
        end else if (bus.pattern_next) begin
            pending_d = 1'b1;
        end
    end

    // Stage 1: capture syncs and reduce coordinates to the few flags the colour mux needs.
    // The pattern is captured alongside so colour and box flags see the same frame's state.
    always_comb begin
        hs_s1_d     = bus.HSync_in;
        vs_s1_d     = bus.VSync_in;
        active_s1_d = (col11 < COLS11) && (row11 < ROWS11);
        inbox_s1_d  = (col11 >= box_x_q) && (col11 < box_x_q + BOX11) &&
                      (row11 >= box_y_q) && (row11 < box_y_q + BOX11);
        chk_s1_d    = bus.col[CHECK_SHIFT] ^ bus.row[CHECK_SHIFT];
        bar_s1_d    = 3'(bus.col / 10'(BAR_WIDTH));
        pat_s1_d    = pattern_q;
    end

    // Stage 2: colour mux with blanking forced to black
    always_comb begin
        hs_s2_d  = hs_s1_q;
        vs_s2_d  = vs_s1_q;
        rgb_s2_d = '0;
        if (active_s1_q) begin
            unique case (pat_s1_q)
                PAT_SOLID: rgb_s2_d = 3'b111;
                PAT_BARS:  rgb_s2_d = 3'd7 - bar_s1_q;
                PAT_CHECK: rgb_s2_d = {3{chk_s1_q}};
                PAT_BOX:   rgb_s2_d = inbox_s1_q ? 3'b111 : 3'b001;
                default:   rgb_s2_d = '0;
            endcase
        end
    end

    // All registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q   <= PAT_SOLID;
            pending_q   <= 1'b0;
            box_x_q     <= '0;
            box_y_q     <= '0;
            dx_neg_q    <= 1'b0;
            dy_neg_q    <= 1'b0;
            hs_s1_q     <= 1'b0;
            vs_s1_q     <= 1'b0;
            active_s1_q <= 1'b0;
            inbox_s1_q  <= 1'b0;
            chk_s1_q    <= 1'b0;
            bar_s1_q    <= '0;
            pat_s1_q    <= PAT_SOLID;
            rgb_s2_q    <= '0;
            hs_s2_q     <= 1'b0;
            vs_s2_q     <= 1'b0;
        end else begin
            pattern_q   <= pattern_d;
            pending_q   <= pending_d;
            box_x_q     <= box_x_d;
            box_y_q     <= box_y_d;
            dx_neg_q    <= dx_neg_d;
            dy_neg_q    <= dy_neg_d;
            hs_s1_q     <= hs_s1_d;
            vs_s1_q     <= vs_s1_d;
            active_s1_q <= active_s1_d;
            inbox_s1_q  <= inbox_s1_d;
            chk_s1_q    <= chk_s1_d;
            bar_s1_q    <= bar_s1_d;
            pat_s1_q    <= pat_s1_d;
            rgb_s2_q    <= rgb_s2_d;
            hs_s2_q     <= hs_s2_d;
            vs_s2_q     <= vs_s2_d;
        end
    end

    assign bus.R         = rgb_s2_q[2];
    assign bus.G         = rgb_s2_q[1];
    assign bus.B         = rgb_s2_q[0];
    assign bus.HSync_out = hs_s2_q;
    assign bus.VSync_out = vs_s2_q;

endmodule
